// File: rtl/silencer_scheduler.sv
// Update-burst sequencer: per tick, streams DEPTH RAM targets into the silencer; STEP swaps only at burst start.
// Latency RD_LATENCY+2 from UPDATE to first DIN_VALID; no DIN backpressure, burst end gated by DOUT_VALID beats, one tick queued.
module silencer_scheduler #(
  parameter int WIDTH      = 13,
  parameter int DEPTH      = 249,
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              UPDATE,
  input  logic [WIDTH-1:0]  STEP_IN,
  input  logic              STEP_WE,
  output logic              RAM_EN,
  output logic [ADDR_W-1:0] RAM_ADDR,
  input  logic [WIDTH-1:0]  RAM_DUTY,
  input  logic [WIDTH-1:0]  RAM_PHASE,
  output logic              DIN_VALID,
  output logic [WIDTH-1:0]  DUTY,
  output logic [WIDTH-1:0]  PHASE,
  output logic [WIDTH-1:0]  STEP,
  input  logic              DOUT_VALID,
  output logic              BUSY,
  output logic              BURST_DONE,
  output logic [15:0]       OVERRUN_CNT
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   BEATS     = (ADDR_W + 1)'(DEPTH);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_W-1:0]     addr;
  logic [ADDR_W:0]       beat_cnt;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [WIDTH-1:0]      shadow;
  logic                  pending;
  logic                  start;
  logic                  drain_done;
  logic                  tick_busy;

  assign start      = (state == IDLE) && (UPDATE || pending);
  assign drain_done = (state == DRAIN) && (beat_cnt == BEATS) && (vld_pipe == '0) && !DIN_VALID;
  assign tick_busy  = UPDATE && (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (UPDATE || pending) state_nxt = FETCH;
      FETCH:   if (addr == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:   if (drain_done)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    RAM_EN     = (state == FETCH);
    RAM_ADDR   = addr;
    BUSY       = (state != IDLE);
    BURST_DONE = drain_done;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr        <= '0;
      beat_cnt    <= '0;
      vld_pipe    <= '0;
      DIN_VALID   <= 1'b0;
      DUTY        <= '0;
      PHASE       <= '0;
      pending     <= 1'b0;
      OVERRUN_CNT <= '0;
      shadow      <= '1;
      STEP        <= '1;
    end else begin
      // valid tracks each issued address through the RAM so data and strobe stay aligned
      vld_pipe[0] <= RAM_EN;
      for (int i = 1; i < RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      DIN_VALID <= vld_pipe[RD_LATENCY-1];
      if (vld_pipe[RD_LATENCY-1]) begin
        DUTY  <= RAM_DUTY;
        PHASE <= RAM_PHASE;
      end

      if (state == FETCH) addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;

      if (start)
        beat_cnt <= '0;
      else if (BUSY && DOUT_VALID && beat_cnt != BEATS)
        beat_cnt <= beat_cnt + 1'b1;

      if (start)
        pending <= 1'b0;
      else if (tick_busy && !pending)
        pending <= 1'b1;

      if (tick_busy && pending && OVERRUN_CNT != 16'hFFFF)
        OVERRUN_CNT <= OVERRUN_CNT + 16'd1;

      // zero step would stall the silencer, so it is promoted to 1
      if (STEP_WE) shadow <= (STEP_IN == '0) ? WIDTH'(1) : STEP_IN;
      if (start)   STEP   <= shadow;
    end
  end

endmodule

// File: tb/tb_silencer_scheduler.sv
// Directed bench for silencer_scheduler: RAM model with 2-cycle read latency and a one-beat-per-input silencer model.
module tb_silencer_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        UPDATE = 1'b0;
  logic [12:0] STEP_IN = '0;
  logic        STEP_WE = 1'b0;
  logic        RAM_EN;
  logic [7:0]  RAM_ADDR;
  logic [12:0] RAM_DUTY;
  logic [12:0] RAM_PHASE;
  logic        DIN_VALID;
  logic [12:0] DUTY;
  logic [12:0] PHASE;
  logic [12:0] STEP;
  logic        DOUT_VALID = 1'b0;
  logic        BUSY;
  logic        BURST_DONE;
  logic [15:0] OVERRUN_CNT;

  silencer_scheduler dut (
    .CLK(CLK), .RST(RST), .UPDATE(UPDATE), .STEP_IN(STEP_IN), .STEP_WE(STEP_WE),
    .RAM_EN(RAM_EN), .RAM_ADDR(RAM_ADDR), .RAM_DUTY(RAM_DUTY), .RAM_PHASE(RAM_PHASE),
    .DIN_VALID(DIN_VALID), .DUTY(DUTY), .PHASE(PHASE), .STEP(STEP),
    .DOUT_VALID(DOUT_VALID), .BUSY(BUSY), .BURST_DONE(BURST_DONE), .OVERRUN_CNT(OVERRUN_CNT)
  );

  always #5 CLK = ~CLK;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   salt = 3;
  int   owed = 0;
  logic stall = 1'b0;
  logic [7:0] ra1 = '0;
  logic [7:0] ra2 = '0;

  int din_cnt, din_first, data_err, addr_err, exp_addr, ram_en_cnt, done_cnt;
  int done_cyc = 0;
  int last_dout = 0;

  function automatic logic [12:0] duty_f(int a, int s);
    return 13'((a * 7 + s) % 8192);
  endfunction

  function automatic logic [12:0] phase_f(int a, int s);
    return 13'((a * 29 + s * 3 + 11) % 8192);
  endfunction

  // RAM with 2-cycle read latency, silencer returning one beat per accepted input
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    ra1 <= RAM_ADDR;
    ra2 <= ra1;
    if (DOUT_VALID) last_dout <= cyc;
    if (RST) owed <= 0;
    else     owed <= owed + int'(DIN_VALID) - int'(DOUT_VALID);
  end

  always @* begin
    RAM_DUTY  = duty_f(int'(ra2), salt);
    RAM_PHASE = phase_f(int'(ra2), salt);
  end

  always @(negedge CLK) begin
    #2;
    DOUT_VALID = (owed > 0) && !stall;
  end

  always @(posedge CLK) begin
    #1;
    if (RAM_EN) begin
      if (int'(RAM_ADDR) != exp_addr) addr_err++;
      exp_addr++;
      ram_en_cnt++;
    end else begin
      exp_addr = 0;
    end
    if (DIN_VALID) begin
      if (din_cnt == 0) din_first = cyc;
      if (DUTY !== duty_f(din_cnt, salt) || PHASE !== phase_f(din_cnt, salt)) data_err++;
      din_cnt++;
    end
    if (BURST_DONE) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic clr();
    din_cnt = 0; data_err = 0; addr_err = 0; ram_en_cnt = 0; done_cnt = 0; din_first = -1;
  endtask

  task automatic pulse_update(output int u);
    u = cyc;
    UPDATE = 1'b1;
    @(negedge CLK);
    UPDATE = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk("burst_done_seen", done_cnt, 1);
  endtask

  task automatic check_burst(string tag, int u);
    chk({tag, "_din_first"}, din_first, u + 4);
    chk({tag, "_din_cnt"}, din_cnt, 249);
    chk({tag, "_data_err"}, data_err, 0);
    chk({tag, "_addr_err"}, addr_err, 0);
    chk({tag, "_ram_en_cnt"}, ram_en_cnt, 249);
    chk({tag, "_done_after_last_beat"}, done_cyc, last_dout + 1);
  endtask

  typedef struct {
    logic we;
    int   step_in;
    int   exp_step;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int u, d1, d2, dmy, prev, n;
    vecs[0] = '{1'b1, 100, 100};
    vecs[1] = '{1'b1, 0, 1};
    vecs[2] = '{1'b0, 55, 1};
    vecs[3] = '{1'b1, 8191, 8191};
    clr();

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    chk("rst_busy", BUSY, 0);
    chk("rst_ram_en", RAM_EN, 0);
    chk("rst_ram_addr", RAM_ADDR, 0);
    chk("rst_din_valid", DIN_VALID, 0);
    chk("rst_burst_done", BURST_DONE, 0);
    chk("rst_overrun", OVERRUN_CNT, 0);
    chk("rst_step", STEP, 8191);
    chk("rst_duty", DUTY, 0);
    chk("rst_phase", PHASE, 0);

    prev = 8191;
    for (int i = 0; i < 4; i++) begin
      salt = i * 101 + 3;
      STEP_IN = 13'(vecs[i].step_in);
      STEP_WE = vecs[i].we;
      @(negedge CLK);
      STEP_WE = 1'b0;
      chk("step_hold_idle", STEP, prev);
      clr();
      pulse_update(u);
      chk("step_at_fetch", STEP, vecs[i].exp_step);
      chk("fetch_ram_en", RAM_EN, 1);
      wait_done(400);
      check_burst("vec", u);
      chk("vec_done_cyc", done_cyc, u + 254);
      @(negedge CLK);
      chk("vec_idle_after", BUSY, 0);
      prev = vecs[i].exp_step;
    end

    // queued tick, overrun, mid-FETCH step write, tick on the BURST_DONE cycle
    salt = 777;
    clr();
    pulse_update(u);
    repeat (20) @(negedge CLK);
    pulse_update(dmy);
    chk("pending_no_overrun", OVERRUN_CNT, 0);
    repeat (20) @(negedge CLK);
    STEP_IN = 13'd7;
    STEP_WE = 1'b1;
    @(negedge CLK);
    STEP_WE = 1'b0;
    pulse_update(dmy);
    chk("overrun_one", OVERRUN_CNT, 1);
    chk("step_held_mid_fetch", STEP, 8191);
    wait_done(400);
    check_burst("b2b1", u);
    chk("b2b1_step_at_done", STEP, 8191);
    d1 = done_cyc;
    clr();
    @(negedge CLK);
    chk("b2b_idle_gap", BUSY, 0);
    @(negedge CLK);
    chk("b2b_restart_ram_en", RAM_EN, 1);
    chk("b2b_restart_addr", RAM_ADDR, 0);
    chk("b2b_new_step", STEP, 7);
    wait_done(400);
    check_burst("b2b2", d1 + 1);
    chk("b2b2_done_cyc", done_cyc, d1 + 1 + 254);
    d2 = done_cyc;
    pulse_update(dmy);
    chk("done_tick_idle", BUSY, 0);
    chk("done_tick_no_overrun", OVERRUN_CNT, 1);
    clr();
    @(negedge CLK);
    chk("done_tick_restart", RAM_EN, 1);
    wait_done(400);
    check_burst("b2b3", d2 + 1);
    @(negedge CLK);

    // reset in the middle of FETCH with a tick queued
    salt = 42;
    clr();
    pulse_update(u);
    pulse_update(dmy);
    n = 0;
    while (RAM_ADDR != 8'd120 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("reached_addr120", RAM_ADDR, 120);
    chk("din_active_before_rst", DIN_VALID, 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("midrst_busy", BUSY, 0);
    chk("midrst_ram_en", RAM_EN, 0);
    chk("midrst_din_valid", DIN_VALID, 0);
    chk("midrst_step", STEP, 8191);
    chk("midrst_overrun", OVERRUN_CNT, 0);
    chk("midrst_addr", RAM_ADDR, 0);
    clr();
    repeat (20) @(negedge CLK);
    chk("midrst_no_stray_din", din_cnt, 0);
    chk("midrst_pending_cleared", ram_en_cnt, 0);

    // silencer stalls for 1000 cycles after FETCH
    salt = 555;
    stall = 1'b1;
    clr();
    pulse_update(u);
    repeat (1260) @(negedge CLK);
    chk("stall_busy", BUSY, 1);
    chk("stall_ram_en_cnt", ram_en_cnt, 249);
    chk("stall_no_done", done_cnt, 0);
    chk("stall_din_cnt", din_cnt, 249);
    chk("stall_data_err", data_err, 0);
    stall = 1'b0;
    wait_done(400);
    chk("stall_done_after_last_beat", done_cyc, last_dout + 1);
    @(negedge CLK);
    chk("stall_idle_after", BUSY, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
